// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand/control sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // Bit positions of the ALU controls within a request opcode {m, s1, s0}.
  localparam int OP_M  = 2;
  localparam int OP_S1 = 1;
  localparam int OP_S0 = 0;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREGS = 4;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: one write port, three combinational read ports.
module alu_regfile
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(NREGS)-1:0] ra_addr,
  output logic [WIDTH-1:0]         ra_data,
  input  logic [$clog2(NREGS)-1:0] rb_addr,
  output logic [WIDTH-1:0]         rb_data,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] regs [NREGS];

  // Storage: clear on reset, otherwise single write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];
  assign rd_data = regs[rd_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Register-to-register execute stage wrapped around an external combinational ALU.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [$clog2(NREGS)-1:0] req_src_a,
  input  logic [$clog2(NREGS)-1:0] req_src_b,
  input  logic [$clog2(NREGS)-1:0] req_dst,
  input  logic                     ld_valid,
  input  logic [$clog2(NREGS)-1:0] ld_addr,
  input  logic [WIDTH-1:0]         ld_data,
  output logic                     m,
  output logic                     s1,
  output logic                     s0,
  output logic [WIDTH-1:0]         A,
  output logic [WIDTH-1:0]         B,
  input  logic [WIDTH-1:0]         alu_out,
  output logic                     res_valid,
  output logic [WIDTH-1:0]         res_data,
  output logic [$clog2(NREGS)-1:0] res_dst,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  state_t                     state;
  logic [$clog2(NREGS)-1:0]   dst_q;
  logic [WIDTH-1:0]           src_a_data;
  logic [WIDTH-1:0]           src_b_data;
  logic                       wr_en;
  logic [$clog2(NREGS)-1:0]   wr_addr;
  logic [WIDTH-1:0]           wr_data;

  assign req_ready = (state == IDLE) && !rst;

  // Write-port mux: writeback owns EXEC, loads only land in IDLE, so they never collide.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ld_addr;
    wr_data = ld_data;
    if (state == EXEC) begin
      wr_en   = 1'b1;
      wr_addr = dst_q;
      wr_data = alu_out;
    end else if ((state == IDLE) && ld_valid) begin
      wr_en   = 1'b1;
    end
  end

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .ra_addr (req_src_a),
    .ra_data (src_a_data),
    .rb_addr (req_src_b),
    .rb_data (src_b_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Sequencer FSM with registered operands, controls and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dst_q     <= '0;
      A         <= '0;
      B         <= '0;
      m         <= 1'b0;
      s1        <= 1'b0;
      s0        <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_dst   <= '0;
    end else begin
      case (state)
        IDLE: begin
          res_valid <= 1'b0;
          if (req_valid) begin
            A     <= src_a_data;
            B     <= src_b_data;
            m     <= req_op[OP_M];
            s1    <= req_op[OP_S1];
            s0    <= req_op[OP_S0];
            dst_q <= req_dst;
            state <= EXEC;
          end
        end
        EXEC: begin
          res_valid <= 1'b1;
          res_data  <= alu_out;
          res_dst   <= dst_q;
          state     <= WB;
        end
        WB: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer; ALU modelled as (A + B) mod 16.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [1:0] req_src_a;
  logic [1:0] req_src_b;
  logic [1:0] req_dst;
  logic       ld_valid;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic       m;
  logic       s1;
  logic       s0;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] alu_out;
  logic       res_valid;
  logic [3:0] res_data;
  logic [1:0] res_dst;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;

  int total = 0;
  int bad   = 0;

  // Reference register file contents.
  logic [3:0] ref_r [4];

  always #5 clk = ~clk;

  // External ALU stand-in.
  always_comb alu_out = A + B;

  alu_op_sequencer #(
    .WIDTH (4),
    .NREGS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_src_a (req_src_a),
    .req_src_b (req_src_b),
    .req_dst   (req_dst),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .m         (m),
    .s1        (s1),
    .s0        (s0),
    .A         (A),
    .B         (B),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_dst   (res_dst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] idx);
    rd_addr = idx;
    #1;
    chk4(tag, rd_data, ref_r[idx]);
  endtask

  task automatic noise_load();
    logic [31:0] r;
    r = $urandom;
    ld_valid = r[8];
    ld_addr  = r[1:0];
    ld_data  = r[7:4];
  endtask

  // Direct load issued from an IDLE negedge; takes effect at the next edge.
  task automatic load(input logic [1:0] a, input logic [3:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ref_r[a] = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  // One complete request starting from an IDLE negedge, optionally with a same-edge load.
  // Loads driven during EXEC/WB are random and must be ignored.
  task automatic issue(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [1:0] dst, input logic ldv, input logic [1:0] lda,
                       input logic [3:0] ldd);
    logic [3:0] ea, eb, er;
    chk1("ready_before_req", req_ready, 1'b1);
    ea = ref_r[sa];
    eb = ref_r[sb];
    er = ea + eb;
    req_valid = 1'b1;
    req_op    = op;
    req_src_a = sa;
    req_src_b = sb;
    req_dst   = dst;
    ld_valid  = ldv;
    ld_addr   = lda;
    ld_data   = ldd;
    if (ldv) ref_r[lda] = ldd;
    @(negedge clk);
    req_valid = 1'b0;
    noise_load();
    chk4("exec_A", A, ea);
    chk4("exec_B", B, eb);
    chk1("exec_m", m, op[2]);
    chk1("exec_s1", s1, op[1]);
    chk1("exec_s0", s0, op[0]);
    chk1("exec_res_valid", res_valid, 1'b0);
    chk1("exec_ready", req_ready, 1'b0);
    @(negedge clk);
    noise_load();
    ref_r[dst] = er;
    chk1("wb_res_valid", res_valid, 1'b1);
    chk4("wb_res_data", res_data, er);
    chk4("wb_res_dst", {2'b00, res_dst}, {2'b00, dst});
    check_reg("wb_rd_dst", dst);
    @(negedge clk);
    ld_valid = 1'b0;
    chk1("idle_res_valid", res_valid, 1'b0);
    chk1("idle_ready", req_ready, 1'b1);
    chk4("idle_A_held", A, ea);
    chk1("idle_m_held", m, op[2]);
    chk1("idle_s0_held", s0, op[0]);
    chk4("idle_res_data_held", res_data, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    req_valid = 1'b0; req_op = '0; req_src_a = '0; req_src_b = '0; req_dst = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    for (int i = 0; i < 4; i++) ref_r[i] = '0;

    // Reset held for two edges.
    @(negedge clk);
    @(negedge clk);
    chk1("rst_ready", req_ready, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk4("rst_A", A, 4'h0);
    chk4("rst_B", B, 4'h0);
    chk4("rst_ctrl", {1'b0, m, s1, s0}, 4'h0);
    chk4("rst_res_data", res_data, 4'h0);
    chk4("rst_res_dst", {2'b00, res_dst}, 4'h0);
    for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i));
    rst = 1'b0;
    @(negedge clk);
    chk1("ready_after_rst", req_ready, 1'b1);

    // Basic operation: r2 = 1010 + 0111 = 0001.
    load(2'd0, 4'b1010);
    load(2'd1, 4'b0111);
    issue(3'b000, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 4'h0);
    chk4("basic_r2", ref_r[2], 4'h1);

    // Control mapping.
    issue(3'b101, 2'd1, 2'd0, 2'd3, 1'b0, 2'd0, 4'h0);

    // Back-to-back: r2 = r0 + r1, then r3 = r2 + r2 with req_valid held.
    req_valid = 1'b1; req_op = 3'b000; req_src_a = 2'd0; req_src_b = 2'd1; req_dst = 2'd2;
    @(negedge clk);
    chk4("b2b_A1", A, 4'hA);
    chk1("b2b_busy1", req_ready, 1'b0);
    req_op = 3'b011; req_src_a = 2'd2; req_src_b = 2'd2; req_dst = 2'd3;
    @(negedge clk);
    chk1("b2b_res1_valid", res_valid, 1'b1);
    chk4("b2b_res1", res_data, 4'h1);
    chk1("b2b_busy2", req_ready, 1'b0);
    @(negedge clk);
    chk1("b2b_ready_at_3", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk4("b2b_A2_updated", A, 4'h1);
    chk4("b2b_B2_updated", B, 4'h1);
    chk1("b2b_s1", s1, 1'b1);
    chk1("b2b_busy3", req_ready, 1'b0);
    @(negedge clk);
    chk1("b2b_res2_valid", res_valid, 1'b1);
    chk4("b2b_res2", res_data, 4'h2);
    chk4("b2b_res2_dst", {2'b00, res_dst}, 4'h3);
    ref_r[2] = 4'h1;
    ref_r[3] = 4'h2;
    @(negedge clk);
    check_reg("b2b_r3", 2'd3);

    // Same-edge load and request: operand sees old r0, load still lands.
    issue(3'b010, 2'd0, 2'd3, 2'd1, 1'b1, 2'd0, 4'hF);
    check_reg("same_edge_r0", 2'd0);

    // Reset during EXEC aborts the writeback.
    req_valid = 1'b1; req_op = 3'b000; req_src_a = 2'd0; req_src_b = 2'd0; req_dst = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) ref_r[i] = '0;
    @(negedge clk);
    chk1("abort_res_valid", res_valid, 1'b0);
    chk1("abort_ready_in_rst", req_ready, 1'b0);
    check_reg("abort_dst", 2'd2);
    rst = 1'b0;
    @(negedge clk);
    chk1("abort_res_valid2", res_valid, 1'b0);
    chk1("abort_idle", req_ready, 1'b1);
    check_reg("abort_dst2", 2'd2);

    // Randomized traffic against the reference register file.
    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      if (r[0]) begin
        load(r[2:1], r[6:3]);
      end else begin
        issue(r[9:7], r[11:10], r[13:12], r[15:14], r[16], r[18:17], r[22:19]);
      end
      r = $urandom;
      check_reg("rand_reg", r[1:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Operand/control sequencer directly upstream of the 4-bit ALU. It holds a small register file and accepts operation requests over a valid/ready handshake. For each request it drives the ALU's mode/select controls and A/B operands from registered outputs, captures the ALU result one cycle later, and writes it back to a destination register. The ALU itself remains combinational and external; this block turns it into a register-to-register execute stage.

## Interface
Parameters:
- WIDTH, 4, datapath width; equals ALU operand width.
- NREGS, 4, register file depth; index width is log2(NREGS) = 2.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  operation request valid.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_op  in  3  {m, s1, s0} passed to the ALU.
- req_src_a, req_src_b  in  2  source register indices for A and B.
- req_dst  in  2  destination register index.
- ld_valid  in  1  direct register load strobe.
- ld_addr  in  2  load target index.
- ld_data  in  WIDTH  load value.
- m, s1, s0  out  1 each  registered ALU controls.
- A, B  out  WIDTH  registered ALU operands.
- alu_out  in  WIDTH  ALU result, combinational from A/B/m/s1/s0.
- res_valid  out  1  one-cycle pulse when writeback occurs.
- res_data  out  WIDTH  last written-back value; holds until the next writeback.
- res_dst  out  2  destination index of the last writeback.
- rd_addr  in  2  debug read index.
- rd_data  out  WIDTH  combinational read of reg[rd_addr].

## Operation
- FSM states: IDLE, EXEC, WB.
  - IDLE -> EXEC on req_valid && req_ready.
  - EXEC -> WB unconditionally.
  - WB -> IDLE unconditionally.
- req_ready = (state == IDLE) and not in reset.
- On acceptance:
  - Latch reg[src_a] into A and reg[src_b] into B.
  - Latch req_op into {m, s1, s0}.
  - Latch req_dst internally.
- EXEC: A, B and controls are held stable; the ALU settles.
- End of EXEC: alu_out is written to reg[dst], res_data and res_dst; res_valid is set for the WB cycle.
- A, B, m, s1, s0 hold their values through WB and IDLE until the next acceptance.
- ld_valid is honoured only in IDLE and ignored otherwise.
  - If a load and an accepted request occur on the same edge, operands use pre-edge register values. The load still takes effect.
- No forwarding is needed. Writeback completes before the next acceptance, so a dependent request always reads the updated value.
- Arithmetic belongs to the ALU. This block does no width extension; alu_out is stored as-is, WIDTH bits, with no carry.
- All register indices wrap naturally within 2 bits; NREGS = 4 covers every index.

## Timing
- Reset (rst high at an edge):
  - FSM goes to IDLE.
  - All registers, A, B, m, s1, s0, res_data and res_dst are cleared to 0.
  - res_valid = 0; req_ready = 0 while rst is high, then 1 in the first cycle after release.
- Request accepted at edge k:
  - Operands appear in cycle k..k+1.
  - Writeback happens at edge k+1.
  - res_valid is high in cycle k+1..k+2.
  - req_ready returns high after edge k+2.
- Throughput: one operation per 3 cycles. Latency from acceptance to result: 2 edges.
- Reset mid-operation (EXEC or WB) aborts the operation: no writeback, and res_valid goes to 0 at that edge.
- req_valid held high continuously produces back-to-back acceptances every 3 cycles.

## Structure
- Shared package alu_seq_pkg holds:
  - state enum (IDLE, EXEC, WB);
  - op bit positions (M = 2, S1 = 1, S0 = 0);
  - default WIDTH and NREGS constants.
- One sub-module, alu_regfile:
  - NREGS x WIDTH storage with synchronous reset;
  - one write port muxed between the load and writeback paths;
  - three combinational read ports (src_a, src_b, rd).
  - Writeback and load never collide, because loads are only accepted in IDLE.
- FSM, operand and control registers, and the result register live in the top level.

## Test plan
The bench models the ALU as alu_out = (A + B) mod 16 for every op.
- Reset:
  - Hold rst for 2 cycles, then check all outputs are 0 and req_ready = 0 during reset.
  - Check req_ready = 1 in the first cycle after release.
- Basic operation:
  - Load r0 = 4'b1010 and r1 = 4'b0111, then request op = 000, src_a = 0, src_b = 1, dst = 2.
  - In the next cycle expect A = 1010, B = 0111, m/s1/s0 = 0/0/0.
  - Then expect a single res_valid pulse with res_data = 4'h1 and res_dst = 2, and rd_addr = 2 reading 4'h1.
- Control mapping: request op = 101 and check m = 1, s1 = 0, s0 = 1 during EXEC, held until the next acceptance.
- Back-to-back dependency:
  - Keep req_valid high with r2 = r0 + r1 followed by r3 = r2 + r2.
  - Expect the second acceptance exactly 3 cycles after the first.
  - Expect the second result to use the updated r2 (r3 = 4'h2).
- Reset during EXEC: no res_valid, reg[dst] unchanged, and the FSM is in IDLE one cycle after rst is released.
- Load and request on the same edge: ld r0 = 4'hF together with a request reading r0 (old value 4'hA). Expect A = 4'hA, and r0 reads 4'hF afterwards.
